// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Next-address controller for a microprogrammed control unit. Each cycle it
// selects the next microstore address from the decode encoder, the
// incrementer, the control-register next-address field, a one-level return
// register, or the current address (hold). The choice is steered by a tested
// status bit (MOC, Cond, TBit or constant 0), optionally inverted.
//
// Parameters:
//   AW         address width (microstore depth 2^AW)
//   RESET_ADDR address loaded on reset, also the reset value of Ret
//   TRAP_ADDR  address forced when a MOC wait times out
//   TIMEOUT    max hold evaluations of a wait before trapping (2..255)
//
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   asynchronous, active-high; clears all state
//   Cond      in   condition-tester result
//   MOC       in   memory operation complete
//   TBit      in   auxiliary test bit (instruction L/U bit)
//   Enc       in   decode-encoder target address
//   CrAddr    in   next-address field from the control register
//   NS        in   next-state select N2N1N0
//   Inv       in   invert the tested bit
//   CondSel   in   test source: 00 MOC, 01 Cond, 10 TBit, 11 constant 0
//   NextAddr  out  combinational next address
//   Addr      out  registered current microstore address
//   Fault     out  registered one-cycle trap pulse
//
// Optional feature (macro MICRO_SEQ_TIMEOUT_EN):
//   Defined     - wait counter and trap to TRAP_ADDR on timeout are built.
//   Not defined - a wait (NS=101, T=0) holds forever and Fault is tied 0.
// -----------------------------------------------------------------------------
module micro_sequencer #(
    parameter int              AW         = 6,
    parameter logic [AW-1:0]   RESET_ADDR = {AW{1'b0}},
    parameter logic [AW-1:0]   TRAP_ADDR  = {AW{1'b1}},
    parameter int              TIMEOUT    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Cond,
    input  logic          MOC,
    input  logic          TBit,
    input  logic [AW-1:0] Enc,
    input  logic [AW-1:0] CrAddr,
    input  logic [2:0]    NS,
    input  logic          Inv,
    input  logic [1:0]    CondSel,
    output logic [AW-1:0] NextAddr,
    output logic [AW-1:0] Addr,
    output logic          Fault
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [AW-1:0] ret_q;
    logic [AW-1:0] ret_d;
    logic [AW-1:0] incr_s;
    logic          src_s;
    logic          t_s;
    logic          hold_s;

`ifdef MICRO_SEQ_TIMEOUT_EN
    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT - 1);

    logic [WCW-1:0] wcnt_q;
    logic [WCW-1:0] wcnt_d;
    logic           fault_q;
    logic           fault_d;
`else
    // Trap parameters have no function in this build; fold them into a sink.
    logic unused_cfg_s;
    assign unused_cfg_s = ^{TRAP_ADDR, 8'(TIMEOUT)};
`endif

    // Tested-bit selection and polarity.
    always_comb begin
        src_s = 1'b0;
        case (CondSel)
            2'b00:   src_s = MOC;
            2'b01:   src_s = Cond;
            2'b10:   src_s = TBit;
            2'b11:   src_s = 1'b0;
            default: src_s = 1'b0;
        endcase
        t_s = src_s ^ Inv;
    end

    assign incr_s = addr_q + {{(AW-1){1'b0}}, 1'b1};

    // Next-address select, return-register update and wait/trap handling.
    always_comb begin
        addr_d = addr_q;
        ret_d  = ret_q;
        hold_s = 1'b0;
        case (NS)
            3'b000:  addr_d = Enc;
            3'b001:  addr_d = incr_s;
            3'b010:  addr_d = CrAddr;
            3'b011:  addr_d = t_s ? CrAddr : incr_s;
            3'b100:  addr_d = t_s ? CrAddr : Enc;
            3'b101: begin
                if (t_s) begin
                    addr_d = incr_s;
                end else begin
                    addr_d = addr_q;
                    hold_s = 1'b1;
                end
            end
            3'b110: begin
                addr_d = CrAddr;
                ret_d  = incr_s;
            end
            3'b111:  addr_d = ret_q;
            default: addr_d = addr_q;
        endcase
`ifdef MICRO_SEQ_TIMEOUT_EN
        wcnt_d  = {WCW{1'b0}};
        fault_d = 1'b0;
        if (hold_s) begin
            // The last permitted evaluation becomes a trap instead of a hold.
            if (wcnt_q == WC_LAST) begin
                addr_d  = TRAP_ADDR;
                fault_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + {{(WCW-1){1'b0}}, 1'b1};
            end
        end else begin
            wcnt_d = {WCW{1'b0}};
        end
`endif
    end

    // Address and return-register state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q <= RESET_ADDR;
            ret_q  <= RESET_ADDR;
        end else begin
            addr_q <= addr_d;
            ret_q  <= ret_d;
        end
    end

`ifdef MICRO_SEQ_TIMEOUT_EN
    // Wait counter and trap pulse state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wcnt_q  <= {WCW{1'b0}};
            fault_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            fault_q <= fault_d;
        end
    end

    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    assign NextAddr = addr_d;
    assign Addr     = addr_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for micro_sequencer (AW=6, RESET_ADDR=0, TRAP_ADDR=63,
// TIMEOUT=4). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Cond;
    logic       MOC;
    logic       TBit;
    logic [5:0] Enc;
    logic [5:0] CrAddr;
    logic [2:0] NS;
    logic       Inv;
    logic [1:0] CondSel;
    logic [5:0] NextAddr;
    logic [5:0] Addr;
    logic       Fault;

    int n_checks = 0;
    int n_fail   = 0;

    micro_sequencer #(
        .AW        (6),
        .RESET_ADDR(6'd0),
        .TRAP_ADDR (6'd63),
        .TIMEOUT   (4)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Cond    (Cond),
        .MOC     (MOC),
        .TBit    (TBit),
        .Enc     (Enc),
        .CrAddr  (CrAddr),
        .NS      (NS),
        .Inv     (Inv),
        .CondSel (CondSel),
        .NextAddr(NextAddr),
        .Addr    (Addr),
        .Fault   (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Cond = 1'b0; MOC = 1'b0; TBit = 1'b0; Enc = 6'd0;
        CrAddr = 6'd0; NS = 3'b001; Inv = 1'b0; CondSel = 2'b00;
        #2;
        n_checks++;
        if (Addr !== 6'd0) begin
            n_fail++; $display("FAIL reset_addr: Addr=%0d expected 0", Addr);
        end
        n_checks++;
        if (Fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_fault: Fault=%0b expected 0", Fault);
        end
        n_checks++;
        if (NextAddr !== 6'd1) begin
            n_fail++; $display("FAIL reset_next: NextAddr=%0d expected 1", NextAddr);
        end
        tick();
        n_checks++;
        if (Addr !== 6'd0) begin
            n_fail++; $display("FAIL reset_held: Addr=%0d expected 0", Addr);
        end
        Reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (Addr !== 6'(i)) begin
                n_fail++; $display("FAIL incr_run: Addr=%0d expected %0d", Addr, i);
            end
        end
        // Asynchronous reset mid-cycle at Addr=5.
        #3;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (Addr !== 6'd0) begin
            n_fail++; $display("FAIL async_reset: Addr=%0d expected 0", Addr);
        end
        tick();
        Reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (Addr !== 6'(i)) begin
                n_fail++; $display("FAIL release_incr: Addr=%0d expected %0d", Addr, i);
            end
        end
    endtask

    task automatic test_wrap_decode();
        NS = 3'b010; CrAddr = 6'd63;
        tick();
        n_checks++;
        if (Addr !== 6'd63) begin
            n_fail++; $display("FAIL jump63: Addr=%0d expected 63", Addr);
        end
        NS = 3'b001;
        #1;
        n_checks++;
        if (NextAddr !== 6'd0) begin
            n_fail++; $display("FAIL wrap_next: NextAddr=%0d expected 0", NextAddr);
        end
        tick();
        n_checks++;
        if (Addr !== 6'd0) begin
            n_fail++; $display("FAIL wrap: Addr=%0d expected 0", Addr);
        end
        NS = 3'b000; Enc = 6'd20;
        tick();
        n_checks++;
        if (Addr !== 6'd20) begin
            n_fail++; $display("FAIL decode: Addr=%0d expected 20", Addr);
        end
    endtask

    task automatic test_branch();
        NS = 3'b011; CondSel = 2'b01; CrAddr = 6'd12; Cond = 1'b1; Inv = 1'b0;
        tick();
        n_checks++;
        if (Addr !== 6'd12) begin
            n_fail++; $display("FAIL br_taken: Addr=%0d expected 12", Addr);
        end
        Cond = 1'b0;
        tick();
        n_checks++;
        if (Addr !== 6'd13) begin
            n_fail++; $display("FAIL br_not_taken: Addr=%0d expected 13", Addr);
        end
        Inv = 1'b1;
        tick();
        n_checks++;
        if (Addr !== 6'd12) begin
            n_fail++; $display("FAIL br_inverted: Addr=%0d expected 12", Addr);
        end
        // NS=100, T=0 -> Enc
        NS = 3'b100; Inv = 1'b0; Enc = 6'd30;
        tick();
        n_checks++;
        if (Addr !== 6'd30) begin
            n_fail++; $display("FAIL br_enc: Addr=%0d expected 30", Addr);
        end
        // TBit source, T=1 -> CrAddr
        CondSel = 2'b10; TBit = 1'b1; CrAddr = 6'd50;
        tick();
        n_checks++;
        if (Addr !== 6'd50) begin
            n_fail++; $display("FAIL br_tbit: Addr=%0d expected 50", Addr);
        end
        // Constant-0 source, NS=011 -> Incr
        CondSel = 2'b11; NS = 3'b011;
        tick();
        n_checks++;
        if (Addr !== 6'd51) begin
            n_fail++; $display("FAIL br_const0: Addr=%0d expected 51", Addr);
        end
        TBit = 1'b0;
    endtask

    task automatic test_wait();
        NS = 3'b010; CrAddr = 6'd9;
        tick();
        NS = 3'b101; CondSel = 2'b00; Inv = 1'b0; MOC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Addr !== 6'd9 || Fault !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: Addr=%0d Fault=%0b expected 9/0", Addr, Fault);
            end
        end
        // MOC arrives on the evaluation that would otherwise time out.
        MOC = 1'b1;
        tick();
        n_checks++;
        if (Addr !== 6'd10 || Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_release: Addr=%0d Fault=%0b expected 10/0", Addr, Fault);
        end
        MOC = 1'b0;
    endtask

    task automatic test_call_return();
        NS = 3'b010; CrAddr = 6'd7;
        tick();
        NS = 3'b110; CrAddr = 6'd40;
        tick();
        n_checks++;
        if (Addr !== 6'd40) begin
            n_fail++; $display("FAIL call: Addr=%0d expected 40", Addr);
        end
        NS = 3'b111;
        tick();
        n_checks++;
        if (Addr !== 6'd8) begin
            n_fail++; $display("FAIL return: Addr=%0d expected 8", Addr);
        end
        tick();
        n_checks++;
        if (Addr !== 6'd8) begin
            n_fail++; $display("FAIL return_again: Addr=%0d expected 8", Addr);
        end
        // Call overwrites Ret: from 8 call 20 -> Ret=9; call again from 20 -> Ret=21
        NS = 3'b110; CrAddr = 6'd20;
        tick();
        tick();
        NS = 3'b111;
        tick();
        n_checks++;
        if (Addr !== 6'd21) begin
            n_fail++; $display("FAIL call_overwrite: Addr=%0d expected 21", Addr);
        end
        // Reset mid-subroutine discards Ret.
        NS = 3'b110; CrAddr = 6'd33;
        tick();
        #2;
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        NS = 3'b111;
        tick();
        n_checks++;
        if (Addr !== 6'd0) begin
            n_fail++; $display("FAIL return_after_reset: Addr=%0d expected 0", Addr);
        end
    endtask

    task automatic test_timeout();
        NS = 3'b010; CrAddr = 6'd9;
        tick();
        NS = 3'b101; CondSel = 2'b00; Inv = 1'b0; MOC = 1'b0;
`ifdef MICRO_SEQ_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (Addr !== 6'd9 || Fault !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold: edge %0d Addr=%0d Fault=%0b expected 9/0", i, Addr, Fault);
            end
        end
        tick();
        n_checks++;
        if (Addr !== 6'd63 || Fault !== 1'b1) begin
            n_fail++;
            $display("FAIL to_trap: Addr=%0d Fault=%0b expected 63/1", Addr, Fault);
        end
        for (int i = 5; i <= 7; i++) begin
            tick();
            n_checks++;
            if (Addr !== 6'd63 || Fault !== 1'b0) begin
                n_fail++;
                $display("FAIL to_post: edge %0d Addr=%0d Fault=%0b expected 63/0", i, Addr, Fault);
            end
        end
        tick();
        n_checks++;
        if (Addr !== 6'd63 || Fault !== 1'b1) begin
            n_fail++;
            $display("FAIL to_repulse: Addr=%0d Fault=%0b expected 63/1", Addr, Fault);
        end
        NS = 3'b001;
        tick();
        n_checks++;
        if (Addr !== 6'd0 || Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL to_exit: Addr=%0d Fault=%0b expected 0/0", Addr, Fault);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            n_checks++;
            if (Addr !== 6'd9 || Fault !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_forever: edge %0d Addr=%0d Fault=%0b expected 9/0", i, Addr, Fault);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_wrap_decode();
        test_branch();
        test_wait();
        test_call_return();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
